// File: rtl/inta_sequencer.sv
// CPU-side 8259A acknowledge sequencer: two INTA_n pulses, vector capture,
// valid/ready hand-off of the vector to the core.
module inta_sequencer #(
  parameter int PULSE_LOW = 2,
  parameter int PULSE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       IF_en,
  input  logic [7:0] D,
  output logic       INTA_n,
  output logic       INTA_1,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy
);

  localparam int MAXP = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    IDLE, P1, GAP, P2, VALID
  } state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          last;

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      cnt_q        <= '0;
      INTA_n       <= 1'b1;
      INTA_1       <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], INT};
      unique case (state_q)
        IDLE: begin
          if (sync_q[1] && IF_en) begin
            state_q <= P1;
            cnt_q   <= CW'(PULSE_LOW);
            INTA_n  <= 1'b0;
            INTA_1  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        P1: begin
          if (last) begin
            state_q <= GAP;
            cnt_q   <= CW'(PULSE_GAP);
            INTA_n  <= 1'b1;
            INTA_1  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (last) begin
            state_q <= P2;
            cnt_q   <= CW'(PULSE_LOW);
            INTA_n  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        P2: begin
          // D is only trusted on the closing edge of the second pulse
          if (last) begin
            state_q      <= VALID;
            INTA_n       <= 1'b1;
            vector       <= D;
            vector_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        VALID: begin
          if (vector_ready) begin
            state_q      <= IDLE;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: default timing instance plus a
// PULSE_LOW=1 / PULSE_GAP=3 instance.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       int_i, ifen, rdy;
  logic [7:0] d;
  logic       na, a1a, va, ba;
  logic [7:0] veca;
  logic       nb, a1b, vb, bb;
  logic [7:0] vecb;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  inta_sequencer u_a (
    .clk(clk), .reset(rst_a), .INT(int_i), .IF_en(ifen), .D(d),
    .INTA_n(na), .INTA_1(a1a), .vector(veca), .vector_valid(va),
    .vector_ready(rdy), .busy(ba)
  );

  inta_sequencer #(.PULSE_LOW(1), .PULSE_GAP(3)) u_b (
    .clk(clk), .reset(rst_b), .INT(int_i), .IF_en(ifen), .D(d),
    .INTA_n(nb), .INTA_1(a1b), .vector(vecb), .vector_valid(vb),
    .vector_ready(rdy), .busy(bb)
  );

  task automatic chk(input string tag, input logic [7:0] o,
                     input logic [7:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called at a negedge; INT rises before the next edge (edge k),
  // step i is observed after edge k+i.
  task automatic ack_run(input bit b, input int n, input int idrop,
                         input logic [9:0] en, input logic [9:0] e1,
                         input logic [9:0] ev, input logic [9:0] eb,
                         input logic [7:0] dv, input int d0,
                         input int d1);
    int_i = 1'b1;
    d = 8'h11;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("inta_n[%0d]", i), b ? nb : na, en[i]);
      chk($sformatf("inta_1[%0d]", i), b ? a1b : a1a, e1[i]);
      chk($sformatf("valid[%0d]", i), b ? vb : va, ev[i]);
      chk($sformatf("busy[%0d]", i), b ? bb : ba, eb[i]);
      if (i == n - 2) chk("vector", b ? vecb : veca, dv);
      if (i == idrop) int_i = 1'b0;
      d = (i >= d0 && i <= d1) ? dv : 8'h11;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    int_i = 1'b1; ifen = 1'b1; d = 8'h00; rdy = 1'b0;

    // 1: reset holds everything quiet despite INT & IF_en
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_inta_n", na, 1'b1);
      chk("rst_busy", ba, 1'b0);
      chk("rst_valid", va, 1'b0);
    end
    int_i = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    chk("rst_vector", veca, 8'h00);
    @(negedge clk);

    // 2: default handshake, D=4A in P2, ready already high
    rdy = 1'b1;
    ack_run(1'b0, 10, 2, 10'b1100110011, 10'b0000001100,
            10'b0100000000, 10'b0111111100, 8'h4A, 6, 7);
    @(negedge clk);

    // 3: IF_en low blocks the request
    ifen = 1'b0; int_i = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ifen0_inta_n", na, 1'b1);
    end
    chk("ifen0_busy", ba, 1'b0);
    ifen = 1'b1;
    d = 8'h11;

    // 4: P1 one edge later; vector held while ready is low
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk($sformatf("t4_inta_n[%0d]", j), na,
          (j < 2 || (j >= 4 && j < 6)) ? 1'b0 : 1'b1);
      chk($sformatf("t4_valid[%0d]", j), va, (j >= 6) ? 1'b1 : 1'b0);
      if (j >= 6) chk($sformatf("t4_vector[%0d]", j), veca, 8'h4A);
      if (j == 0) int_i = 1'b0;
      d = (j >= 6) ? 8'hFF : (j >= 4) ? 8'h4A : 8'h11;
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("t4_valid_clr", va, 1'b0);
    chk("t4_busy_clr", ba, 1'b0);
    chk("t4_vector_keep", veca, 8'h4A);
    @(negedge clk);

    // 5: INT drops in GAP, spurious IR7 vector still captured
    ack_run(1'b0, 10, 4, 10'b1100110011, 10'b0000001100,
            10'b0100000000, 10'b0111111100, 8'h47, 6, 7);
    @(negedge clk);

    // 6: reset in the middle of P2 releases INTA_n without a clock
    int_i = 1'b1;
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("t6_in_p2", na, 1'b0);
    #2 rst_a = 1'b1;
    #1;
    chk("t6_async_inta_n", na, 1'b1);
    chk("t6_async_busy", ba, 1'b0);
    int_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("t6_post_valid", va, 1'b0);
    chk("t6_post_busy", ba, 1'b0);
    chk("t6_post_inta_n", na, 1'b1);

    // 6b: PULSE_LOW=1, PULSE_GAP=3 -> widths 1/3/1
    rst_b = 1'b0;
    @(negedge clk);
    ack_run(1'b1, 9, 2, 10'b0110111011, 10'b0000000100,
            10'b0010000000, 10'b0011111100, 8'h5C, 6, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
